bram_fetch_ctrl: RTL and testbench

Memory-controller fetch engine between the frame BRAM and the 3-row line buffer that feeds the core. Driven by the top controller's level-held `fetch_run`/`cnt_len`, it computes the BRAM base address of the current 3-row window and issues one read per cycle. It tags each returning word with its buffer row and column and writes it into the line buffer. It pulses `fetch_done` when the last word has landed and reports the window's top image row, which the controller uses for end-of-frame detection.

---
 rtl/bram_fetch_ctrl_if.sv | 30 +++
 rtl/bram_fetch_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_bram_fetch_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bram_fetch_ctrl_if.sv
// Bus bundle between the fetch engine, its controller, the frame BRAM and the line buffer.
// The slave modport is the fetch engine's view; master is the environment driving it.
interface bram_fetch_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              fetch_run_i;
  logic [19:0]       cnt_len_i;
  logic              fetch_done_o;
  logic [9:0]        cnt_img_row_o;
  logic              bram_en_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [DATA_W-1:0] bram_rdata_i;
  logic              buf_wr_en_o;
  logic [1:0]        buf_wr_row_o;
  logic [9:0]        buf_wr_col_o;
  logic [DATA_W-1:0] buf_wr_data_o;

  modport slave (
    input  fetch_run_i, cnt_len_i, bram_rdata_i,
    output fetch_done_o, cnt_img_row_o, bram_en_o, bram_addr_o,
           buf_wr_en_o, buf_wr_row_o, buf_wr_col_o, buf_wr_data_o
  );

  modport master (
    output fetch_run_i, cnt_len_i, bram_rdata_i,
    input  fetch_done_o, cnt_img_row_o, bram_en_o, bram_addr_o,
           buf_wr_en_o, buf_wr_row_o, buf_wr_col_o, buf_wr_data_o
  );
endinterface

// File: rtl/bram_fetch_ctrl.sv
// Fetch engine: streams a 3-row window from the frame BRAM into the line buffer,
// tagging each returning word with its buffer row/column via a latency-matched pipe.
module bram_fetch_ctrl #(
  parameter int MAX_ROW  = 540,
  parameter int MAX_COL  = 540,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int BRAM_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  bram_fetch_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_WAIT_LOW = 3'd4;

  localparam logic [19:0]       LEN_MAX  = 20'(3 * MAX_COL);
  localparam logic [9:0]        COL_LAST = 10'(MAX_COL - 1);
  localparam logic [9:0]        ROW_WRAP = 10'(MAX_ROW - 3);
  localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(MAX_COL);

  logic [2:0]        state_q, state_d;
  logic              first_q, first_d;
  logic [9:0]        row_q, row_d;
  logic [19:0]       len_q, len_d;
  logic [19:0]       cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        bcol_q, bcol_d;
  logic [1:0]        brow_q, brow_d;
  logic              done_q, done_d;
  logic              flush_s;
  logic [19:0]       len_cap_s;
  logic [9:0]        row_nxt_s;

  logic [BRAM_LAT-1:0]       vld_q;
  logic [BRAM_LAT-1:0]       vld_nxt_s;
  logic [BRAM_LAT-1:0][1:0]  prow_q;
  logic [BRAM_LAT-1:0][9:0]  pcol_q;
  logic [DATA_W-1:0]         wr_data_s;

  // Tag valids one cycle ahead: an all-zero value means the last write lands this cycle.
  assign vld_nxt_s = (vld_q << 1) | BRAM_LAT'(en_q);

  // Next-state, window bookkeeping and read-issue decode.
  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    row_d     = row_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    addr_d    = '0;
    bcol_d    = bcol_q;
    brow_d    = brow_q;
    flush_s   = 1'b0;
    len_cap_s = (bus.cnt_len_i > LEN_MAX) ? LEN_MAX : bus.cnt_len_i;
    if (first_q) begin
      row_nxt_s = 10'd0;
    end else if (row_q == ROW_WRAP) begin
      row_nxt_s = 10'd0;
    end else begin
      row_nxt_s = row_q + 10'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.fetch_run_i) begin
          first_d = 1'b0;
          row_d   = row_nxt_s;
          len_d   = len_cap_s;
          cnt_d   = 20'd0;
          bcol_d  = 10'd0;
          brow_d  = 2'd0;
          if (len_cap_s == 20'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
            addr_d  = ADDR_W'(row_nxt_s) * COL_A;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.fetch_run_i) begin
          state_d = S_IDLE;
          flush_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
          // Column/row tag advance without a divider.
          if (bcol_q == COL_LAST) begin
            bcol_d = 10'd0;
            brow_d = brow_q + 2'd1;
          end else begin
            bcol_d = bcol_q + 10'd1;
          end
          if (cnt_q + 20'd1 == len_q) begin
            state_d = S_DRAIN;
          end else begin
            en_d   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!bus.fetch_run_i) begin
          state_d = S_IDLE;
          flush_s = 1'b1;
        end else if (vld_nxt_s == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!bus.fetch_run_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_LOW;
        end
      end
      default: begin
        state_d = S_IDLE;
        flush_s = 1'b1;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      first_q <= 1'b1;
      row_q   <= 10'd0;
      len_q   <= 20'd0;
      cnt_q   <= 20'd0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      bcol_q  <= 10'd0;
      brow_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      row_q   <= row_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      bcol_q  <= bcol_d;
      brow_q  <= brow_d;
      done_q  <= done_d;
    end
  end

  // Tag pipe matching BRAM latency; idle slots carry zero tags so outputs stay clean.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_s) begin
      vld_q  <= '0;
      prow_q <= '0;
      pcol_q <= '0;
    end else begin
      vld_q     <= vld_nxt_s;
      prow_q[0] <= en_q ? brow_q : 2'd0;
      pcol_q[0] <= en_q ? bcol_q : 10'd0;
      for (int i = 1; i < BRAM_LAT; i++) begin
        prow_q[i] <= prow_q[i-1];
        pcol_q[i] <= pcol_q[i-1];
      end
    end
  end

  assign wr_data_s = vld_q[BRAM_LAT-1] ? bus.bram_rdata_i : '0;

  assign bus.fetch_done_o  = done_q;
  assign bus.cnt_img_row_o = row_q;
  assign bus.bram_en_o     = en_q;
  assign bus.bram_addr_o   = addr_q;
  assign bus.buf_wr_en_o   = vld_q[BRAM_LAT-1];
  assign bus.buf_wr_row_o  = prow_q[BRAM_LAT-1];
  assign bus.buf_wr_col_o  = pcol_q[BRAM_LAT-1];
  assign bus.buf_wr_data_o = wr_data_s;
endmodule

// File: tb/tb_bram_fetch_ctrl.sv
// Bench for bram_fetch_ctrl: directed and randomized fetches compared cycle by cycle
// against a window/arithmetic reference model of the expected BRAM and buffer traffic.
module tb_bram_fetch_ctrl;
  localparam int MAX_ROW = 540;
  localparam int MAX_COL = 540;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int LAT     = 2;
  localparam int LEN_MAX = 3 * MAX_COL;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         exp_row = 0;
  bit         first_fetch = 1'b1;
  logic [7:0] seed = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic [7:0] d2 = 8'h00;

  always #5 clk = ~clk;

  bram_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dif ();

  bram_fetch_ctrl #(
    .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_LAT(LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  function automatic logic [7:0] mem_word(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ {5'd0, v[18:16]} ^ seed;
  endfunction

  // BRAM model with two cycles of read latency.
  always @(posedge clk) begin
    d1 <= dif.bram_en_o ? mem_word(int'(dif.bram_addr_o)) : 8'h00;
    d2 <= d1;
  end
  assign dif.bram_rdata_i = d2;

  function automatic logic [51:0] cur_obs();
    return {dif.fetch_done_o, dif.cnt_img_row_o, dif.bram_en_o, dif.bram_addr_o,
            dif.buf_wr_en_o, dif.buf_wr_row_o, dif.buf_wr_col_o, dif.buf_wr_data_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch from the cycle-0 request to the return to idle; abort_at>0 drops run in that cycle.
  task automatic do_fetch(input int len, input int abort_at, input int hold);
    int n, base, done_c, last_c, prev_row, w, wr_seen, done_seen, last_wr, exp_wr, top;
    bit cut;
    logic e_en, e_wr, e_done;
    logic [18:0] e_addr;
    logic [1:0]  e_brow;
    logic [9:0]  e_bcol;
    logic [7:0]  e_data;
    prev_row = exp_row;
    if (first_fetch) exp_row = 0;
    else if (exp_row == MAX_ROW - 3) exp_row = 0;
    else exp_row = exp_row + 1;
    first_fetch = 1'b0;
    n      = (len > LEN_MAX) ? LEN_MAX : len;
    base   = exp_row * MAX_COL;
    done_c = (n == 0) ? 1 : n + LAT + 1;
    last_c = (abort_at > 0) ? abort_at + 4 : done_c + hold + 2;
    dif.fetch_run_i = 1'b1;
    dif.cnt_len_i   = 20'(len);
    chk($sformatf("idle_c0_len%0d", len), 64'(cur_obs()), 64'({1'b0, 10'(prev_row), 41'd0}));
    wr_seen = 0; done_seen = 0; last_wr = -1;
    for (int k = 1; k <= last_c; k++) begin
      @(posedge clk); #1;
      w      = k - 1 - LAT;
      cut    = (abort_at > 0) && (k > abort_at);
      e_en   = !cut && (k <= n);
      e_addr = e_en ? 19'(base + k - 1) : 19'd0;
      e_wr   = !cut && (w >= 0) && (w < n);
      e_brow = e_wr ? 2'(w / MAX_COL) : 2'd0;
      e_bcol = e_wr ? 10'(w % MAX_COL) : 10'd0;
      e_data = e_wr ? mem_word(base + w) : 8'd0;
      e_done = (abort_at == 0) && (k == done_c);
      chk($sformatf("len%0d_row%0d_c%0d", len, exp_row, k), 64'(cur_obs()),
          64'({e_done, 10'(exp_row), e_en, e_addr, e_wr, e_brow, e_bcol, e_data}));
      if (dif.buf_wr_en_o === 1'b1) begin
        wr_seen++;
        last_wr = int'(dif.buf_wr_row_o) * 1024 + int'(dif.buf_wr_col_o);
      end
      if (dif.fetch_done_o === 1'b1) done_seen++;
      if (abort_at > 0 && k == abort_at) dif.fetch_run_i = 1'b0;
      if (abort_at == 0 && k == done_c + hold + 1) dif.fetch_run_i = 1'b0;
    end
    if (abort_at > 0) begin
      top    = (abort_at < n + LAT) ? abort_at : n + LAT;
      exp_wr = (top - LAT > 0) ? top - LAT : 0;
      chk($sformatf("abort_done_len%0d", len), 64'(done_seen), 64'd0);
    end else begin
      exp_wr = n;
      chk($sformatf("done_count_len%0d", len), 64'(done_seen), 64'd1);
      if (n > 0)
        chk($sformatf("last_wr_len%0d", len), 64'(last_wr),
            64'(((n - 1) / MAX_COL) * 1024 + (n - 1) % MAX_COL));
    end
    chk($sformatf("wr_count_len%0d", len), 64'(wr_seen), 64'(exp_wr));
  endtask

  initial begin
    int len, n, ab;
    seed = 8'($urandom);
    dif.fetch_run_i = 1'b1;
    dif.cnt_len_i   = 20'd1620;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset_c%0d", i), 64'(cur_obs()), 64'd0);
    end
    rst_n = 1'b1;

    do_fetch(1620, 0, 0);     // row 0, addresses 0..1619
    do_fetch(1620, 0, 3);     // row 1, run held 3 cycles past done
    do_fetch(1620, 100, 0);   // row 2, aborted at cycle 100
    do_fetch(1620, 0, 0);     // row 3 after abort
    do_fetch(0, 0, 1);
    do_fetch(5000, 0, 0);
    do_fetch(541, 0, 0);

    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(0, 2000);
      n   = (len > LEN_MAX) ? LEN_MAX : len;
      ab  = (i % 2 == 1 && n > 0) ? $urandom_range(1, n + LAT) : 0;
      do_fetch(len, ab, $urandom_range(0, 3));
    end

    while (exp_row != MAX_ROW - 4) do_fetch($urandom_range(0, 4), 0, 0);
    do_fetch(1620, 0, 0);     // row 537: addresses 289980..291599
    chk("row537_held", 64'(dif.cnt_img_row_o), 64'd537);
    do_fetch($urandom_range(1, 40), 0, 0);
    chk("wrap_row0", 64'(dif.cnt_img_row_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
